// File: rtl/mux_select_sequencer.sv
// Round-robin sequencer driving the select pair of an external 4:1 mux, waiting a settle
// time, capturing mux_out and presenting it on a valid/ready port. Optional: MUX_SEQ_BURST_EN.
module mux_select_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned BURST_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic       mux_out,
  output logic       address0,
  output logic       address1,
  output logic [3:0] grant,
  output logic       sample_valid,
  output logic       sample_data,
  output logic [1:0] sample_chan,
  input  logic       sample_ready,
  output logic [1:0] dbg_state
);

  // Handshake: a sample transfers on any rising edge where sample_valid && sample_ready;
  // once raised, sample_valid and its payload hold until that transfer happens.

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, CAPTURE = 2'd2, HOLD = 2'd3} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES out of range 1..15");
  end
  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst
    $error("BURST_LEN out of range 1..15");
  end

  state_t     state, state_n;
  logic [1:0] rr_ptr;
  logic [3:0] cnt;
  logic [1:0] chan;
  logic [1:0] pick;
  logic       pick_valid;
  logic       burst_more;

  assign chan      = {address1, address0};
  assign dbg_state = state;

  // First requesting channel at or after rr_ptr; scanning offsets high to low lets the
  // smallest offset win.
  always_comb begin
    pick       = rr_ptr;
    pick_valid = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[rr_ptr + 2'(k)]) begin
        pick       = rr_ptr + 2'(k);
        pick_valid = 1'b1;
      end
    end
  end

`ifdef MUX_SEQ_BURST_EN
  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);
  logic [3:0] burst_cnt;
  assign burst_more = req[chan] && (burst_cnt < BURST_MAX);
`else
  assign burst_more = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pick_valid) state_n = SETTLE;
      SETTLE:  if (cnt == 4'd0) state_n = CAPTURE;
      CAPTURE: state_n = HOLD;
      HOLD:    if (sample_ready) state_n = burst_more ? SETTLE : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address0     <= 1'b0;
      address1     <= 1'b0;
      grant        <= 4'b0000;
      sample_valid <= 1'b0;
      sample_data  <= 1'b0;
      sample_chan  <= 2'd0;
      rr_ptr       <= 2'd0;
      cnt          <= 4'd0;
`ifdef MUX_SEQ_BURST_EN
      burst_cnt    <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            {address1, address0} <= pick;
            grant                <= 4'b0001 << pick;
            cnt                  <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        CAPTURE: begin
          sample_data  <= mux_out;
          sample_chan  <= chan;
          sample_valid <= 1'b1;
`ifdef MUX_SEQ_BURST_EN
          burst_cnt    <= burst_cnt + 4'd1;
`endif
        end
        HOLD: begin
          if (sample_ready) begin
            sample_valid <= 1'b0;
            if (burst_more) begin
              cnt <= SETTLE_LOAD;
            end else begin
              grant  <= 4'b0000;
              rr_ptr <= chan + 2'd1;
`ifdef MUX_SEQ_BURST_EN
              burst_cnt <= 4'd0;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench for mux_select_sequencer; models the external 4:1 mux from address0/1.
module tb_mux_select_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       mux_out;
  logic       address0, address1;
  logic [3:0] grant;
  logic       sample_valid, sample_data;
  logic [1:0] sample_chan;
  logic       sample_ready = 1'b1;
  logic [1:0] dbg_state;

  logic [3:0] mux_in = 4'b0000;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  assign mux_out = mux_in[{address1, address0}];

  mux_select_sequencer #(.SETTLE_CYCLES(2), .BURST_LEN(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .mux_out(mux_out),
    .address0(address0), .address1(address1), .grant(grant),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_chan(sample_chan),
    .sample_ready(sample_ready), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!sample_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("valid_seen", 32'(sample_valid), 32'd1);
  endtask

  // Waits for a sample, records it, then steps past the accepting edge (sample_ready=1).
  task automatic collect(output logic [1:0] ch, output logic d, output int stamp);
    wait_valid();
    ch    = sample_chan;
    d     = sample_data;
    stamp = cyc;
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] ch;
    logic       d;
    int         st, prev_st;
    logic [1:0] exp_ch;
    logic [1:0] hold_chan;
    logic       hold_data;
    logic [1:0] hold_addr;

    // 1 reset with all requests pending
    req = 4'b1111;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_addr", 32'({address1, address0}), 32'h0);
    check("rst_valid", 32'(sample_valid), 32'h0);
    check("rst_data", 32'(sample_data), 32'h0);
    check("rst_chan", 32'(sample_chan), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("first_grant", 32'(grant), 32'h1);
    check("first_addr", 32'({address1, address0}), 32'h0);
    req = 4'b0000;
    collect(ch, d, st);
    check("first_chan", 32'(ch), 32'h0);

    // 2 single channel, latency 3 edges
    mux_in = 4'b0100;
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    check("single_addr", 32'({address1, address0}), 32'h2);
    check("single_grant", 32'(grant), 32'h4);
    check("single_v0", 32'(sample_valid), 32'h0);
    @(negedge clk);
    check("single_v1", 32'(sample_valid), 32'h0);
    @(negedge clk);
    check("single_v2", 32'(sample_valid), 32'h0);
    @(negedge clk);
    check("single_v3", 32'(sample_valid), 32'h1);
    check("single_data", 32'(sample_data), 32'h1);
    check("single_chan", 32'(sample_chan), 32'h2);
    @(negedge clk);
    check("single_pulse", 32'(sample_valid), 32'h0);
    repeat (4) @(negedge clk);
    check("single_no_repeat", 32'(sample_valid), 32'h0);
    check("single_grant_off", 32'(grant), 32'h0);

    // 3 round robin from pointer 0, in0..in3 = 1,0,1,0
    do_reset();
    mux_in = 4'b0101;
    req = 4'b1111;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    prev_st = 0;
    for (int i = 0; i < 5; i++) begin
      collect(ch, d, st);
      exp_ch = exp_q.pop_front();
      check("rr_chan", 32'(ch), 32'(exp_ch));
      check("rr_data", 32'(d), 32'(mux_in[exp_ch]));
      if (i > 0) check("rr_spacing", 32'(st - prev_st), 32'd5);
      prev_st = st;
    end

    // 4 backpressure for 10 cycles
    do_reset();
    req = 4'b0000;
    mux_in = 4'b0010;
    sample_ready = 1'b0;
    req = 4'b0010;
    wait_valid();
    req = 4'b0000;
    hold_chan = sample_chan;
    hold_data = sample_data;
    hold_addr = {address1, address0};
    check("bp_chan", 32'(hold_chan), 32'h1);
    check("bp_data", 32'(hold_data), 32'h1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(sample_valid), 32'h1);
      check("bp_stable", 32'({sample_chan, sample_data, address1, address0}),
            32'({hold_chan, hold_data, hold_addr}));
    end
    sample_ready = 1'b1;
    @(negedge clk);
    check("bp_accept", 32'(sample_valid), 32'h0);
    check("bp_idle", 32'(dbg_state), 32'h0);
    check("bp_grant", 32'(grant), 32'h0);
    repeat (5) @(negedge clk);
    check("bp_single", 32'(sample_valid), 32'h0);

    // 5 reset during SETTLE for chan 3
    do_reset();
    mux_in = 4'b1000;
    req = 4'b1000;
    @(negedge clk);
    check("mid_grant", 32'(grant), 32'h8);
    check("mid_state", 32'(dbg_state), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_async_grant", 32'(grant), 32'h0);
    check("mid_async_state", 32'(dbg_state), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_no_sample", 32'(sample_valid), 32'h0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_regrant", 32'(grant), 32'h8);
    check("mid_addr", 32'({address1, address0}), 32'h3);
    req = 4'b0000;
    collect(ch, d, st);
    check("mid_chan", 32'(ch), 32'h3);
    check("mid_data", 32'(d), 32'h1);

    // 6 two requesters held
    do_reset();
    mux_in = 4'b0000;
    req = 4'b0011;
`ifdef MUX_SEQ_BURST_EN
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
`else
    exp_q = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
    while (exp_q.size() > 0) begin
      collect(ch, d, st);
      exp_ch = exp_q.pop_front();
      check("pair_chan", 32'(ch), 32'(exp_ch));
    end
    req = 4'b0000;

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
